// File: rtl/alu_seq.sv
// Command FIFO feeding an external combinational ALU through a 3-state sequencer.
// Optional result flags (res_zero, res_neg) are enabled with `define ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [7:0]               alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [2:0]               res_op,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                     res_zero,
  output logic                     res_neg
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  cmd_t          mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_op_q, res_op_d;
  logic          push, pop;
  cmd_t          head;
`ifdef ALU_SEQ_FLAGS_EN
  logic          res_zero_q, res_zero_d, res_neg_q, res_neg_d;
`endif

  // Ready looks only at registered occupancy, so it never waits on a same-cycle pop.
  assign cmd_ready = (count_q < FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
`ifdef ALU_SEQ_FLAGS_EN
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_result;
        res_op_d    = alu_op_q;
        res_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        res_zero_d  = (alu_result == 8'h00);
        res_neg_d   = alu_result[7];
`endif
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      alu_a_d  = head.a;
      alu_b_d  = head.b;
      alu_op_d = head.op;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign fifo_count = count_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign res_zero   = res_zero_q;
  assign res_neg    = res_neg_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; the combinational ALU is modelled here.
module tb_alu_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SEQ_FLAGS_EN
  logic       res_zero, res_neg;
`endif

  int checks = 0;
  int errors = 0;

  alu_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .fifo_count(fifo_count)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_opcode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns 1 time unit after the edge that accepted it.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin step(); n++; end
    check("push_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] d, input logic [2:0] op);
    int n = 0;
    while (res_valid !== 1'b1 && n < 50) begin step(); n++; end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, d);
    check({tag, "_op"}, res_op, op);
    if (res_ready) step();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] a, b;
    logic [2:0] op;
    int seen;

    // Reset with a command offered; it must not be taken.
    cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 3'b000;
    step(); step();
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    step(); step();
    check("post_rst_count", fifo_count, 0);
    check("post_rst_valid", res_valid, 0);

    // Basic op with exact latency.
    res_ready = 1'b1;
    push(8'h0A, 8'h05, 3'b000);
    check("lat_n0_valid", res_valid, 0);
    step();
    check("lat_n1_valid", res_valid, 0);
    step();
    check("lat_n2_valid", res_valid, 1);
    check("lat_n2_data", res_data, 8'h0F);
    check("lat_n2_op", res_op, 3'b000);
    step();
    check("after_hs_valid", res_valid, 0);
    push(8'h0A, 8'h05, 3'b001);
    wait_result("sub", 8'h05, 3'b001);

    // Back-pressure: five accepted, sixth refused.
    res_ready = 1'b0;
    push(8'h01, 8'h02, 3'b000);
    push(8'h09, 8'h03, 3'b001);
    push(8'hF0, 8'h3C, 3'b010);
    push(8'hF0, 8'h0F, 3'b011);
    push(8'h55, 8'h00, 3'b100);
    cmd_a = 8'h77; cmd_b = 8'h01; cmd_op = 3'b000; cmd_valid = 1'b1;
    step();
    check("bp_ready", cmd_ready, 0);
    check("bp_count", fifo_count, 4);
    step();
    check("bp_count_hold", fifo_count, 4);
    check("bp_data_held", res_data, 8'h03);
    check("bp_valid_held", res_valid, 1);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_result("bp0", 8'h03, 3'b000);
    wait_result("bp1", 8'h06, 3'b001);
    wait_result("bp2", 8'h30, 3'b010);
    wait_result("bp3", 8'hFF, 3'b011);
    wait_result("bp4", 8'hAA, 3'b100);
    step();
    check("bp_drained_count", fifo_count, 0);
    check("bp_drained_valid", res_valid, 0);

    // Modulo-256 wrap in both directions.
    push(8'hFF, 8'h01, 3'b000);
    while (res_valid !== 1'b1 && seen < 50) begin step(); seen++; end
`ifdef ALU_SEQ_FLAGS_EN
    check("wrap_zero_flag", res_zero, 1);
`endif
    wait_result("wrap_add", 8'h00, 3'b000);
    push(8'h00, 8'h01, 3'b001);
    seen = 0;
    while (res_valid !== 1'b1 && seen < 50) begin step(); seen++; end
`ifdef ALU_SEQ_FLAGS_EN
    check("wrap_neg_flag", res_neg, 1);
`endif
    wait_result("wrap_sub", 8'hFF, 3'b001);

    // Unused opcode yields zero and is passed through.
    push(8'h12, 8'h34, 3'b111);
    wait_result("op111", 8'h00, 3'b111);

    // Steady push/pop at occupancy 2 across pointer wraps.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i * 17 + 5); b = 8'(i * 3 + 1); op = 3'(i);
      exp_q.push_back(alu_ref(a, b, op));
      push(a, b, op);
    end
    seen = 0;
    while (res_valid !== 1'b1 && seen < 50) begin step(); seen++; end
    check("ss_start_count", fifo_count, 2);
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("ss_count", fifo_count, 2);
      if (res_valid === 1'b1) begin
        check("ss_data", res_data, exp_q.pop_front());
        a = 8'(i * 7 + 3); b = 8'(i * 13); op = 3'(i % 5);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        exp_q.push_back(alu_ref(a, b, op));
      end else begin
        cmd_valid = 1'b0;
      end
      step();
    end
    cmd_valid = 1'b0;
    seen = 0;
    while (exp_q.size() > 0 && seen < 100) begin
      if (res_valid === 1'b1) check("ss_drain", res_data, exp_q.pop_front());
      step();
      seen++;
    end
    check("ss_drain_left", exp_q.size(), 0);

    // Reset while holding a result with three queued.
    res_ready = 1'b0;
    push(8'h01, 8'h01, 3'b000);
    push(8'h02, 8'h02, 3'b000);
    push(8'h03, 8'h03, 3'b000);
    push(8'h04, 8'h04, 3'b000);
    check("pre_rst_count", fifo_count, 3);
    check("pre_rst_valid", res_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_alu_a", alu_a, 0);
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid === 1'b1) seen++;
      step();
    end
    check("no_stale_results", seen, 0);
    push(8'h03, 8'h04, 3'b000);
    wait_result("after_rst", 8'h07, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
